// File: rtl/id_pkg.sv
// id_pkg: opcode/funct constants, control encodings and the
// decode helper shared by the MIPS instruction-decode stage.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {
    RD_RT   = 2'b00,
    RD_RD   = 2'b01,
    RD_LINK = 2'b10
  } reg_dst_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_IMM   = 2'b11
  } alu_op_e;

  // Controls that travel through ID/EX.
  typedef struct packed {
    logic     wb_write;
    logic     mem_to_reg;
    logic     mem_read;
    logic     mem_write;
    logic     alu_src;
    reg_dst_e reg_dst;
    alu_op_e  alu_op;
  } ex_ctrl_t;

  // Full decode bundle: ID/EX part plus ID-local controls.
  typedef struct packed {
    ex_ctrl_t ex;
    logic     jump;
    logic     branch;
    logic     bne;
    logic     zext;
  } ctrl_t;

  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        c.ex.wb_write = 1'b1;
        c.ex.reg_dst  = RD_RD;
        c.ex.alu_op   = ALU_FUNCT;
      end
      (op == OP_LW): begin
        c.ex.wb_write   = 1'b1;
        c.ex.mem_to_reg = 1'b1;
        c.ex.mem_read   = 1'b1;
        c.ex.alu_src    = 1'b1;
      end
      (op == OP_SW): begin
        c.ex.mem_write = 1'b1;
        c.ex.alu_src   = 1'b1;
      end
      (op == OP_BEQ): begin
        c.ex.alu_op = ALU_SUB;
        c.branch    = 1'b1;
      end
      (op == OP_BNE): begin
        c.ex.alu_op = ALU_SUB;
        c.branch    = 1'b1;
        c.bne       = 1'b1;
      end
      (op inside {OP_ADDI, OP_SLTI, OP_LUI}): begin
        c.ex.wb_write = 1'b1;
        c.ex.alu_src  = 1'b1;
        c.ex.alu_op   = ALU_IMM;
      end
      (op inside {OP_ANDI, OP_ORI, OP_XORI}): begin
        c.ex.wb_write = 1'b1;
        c.ex.alu_src  = 1'b1;
        c.ex.alu_op   = ALU_IMM;
        c.zext        = 1'b1;
      end
      (op == OP_J): begin
        c.jump = 1'b1;
      end
      (op == OP_JAL): begin
        c.jump        = 1'b1;
        c.ex.wb_write = 1'b1;
        c.ex.reg_dst  = RD_LINK;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: 2R/1W register file, r0 hardwired to zero,
// write-first bypass so a same-cycle writeback is read back.
module id_regfile
  import id_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32,
  parameter int AW      = $clog2(N_REGS)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [AW-1:0]      i_raddr_a,
  input  logic [AW-1:0]      i_raddr_b,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [NB_DATA-1:0] i_wdata,
  output logic [NB_DATA-1:0] o_rdata_a,
  output logic [NB_DATA-1:0] o_rdata_b
);

  logic [NB_DATA-1:0] r_mem [N_REGS];

  // Storage: cleared on reset, r0 never written.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_REGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read ports with zero register and writeback bypass.
  always_comb begin
    o_rdata_a = r_mem[i_raddr_a];
    o_rdata_b = r_mem[i_raddr_b];
    if (i_we && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
    if (i_we && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
    if (i_raddr_a == '0) o_rdata_a = '0;
    if (i_raddr_b == '0) o_rdata_b = '0;
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: MIPS decode, hazards, redirects and ID/EX register.
// Define ID_BRANCH_EN to resolve BEQ/BNE in ID with forwarding.
module id_stage
  import id_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int N_REGS  = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_flush,
  input  logic [NB_DATA-1:0] i_pc4,
  input  logic [31:0]        i_instruction,
  input  logic               i_wb_write,
  input  logic [4:0]         i_wb_addr,
  input  logic [NB_DATA-1:0] i_wb_data,
  input  logic               i_ex_mem_read,
  input  logic               i_ex_write,
  input  logic [4:0]         i_ex_dst,
  input  logic               i_mem_mem_read,
  input  logic               i_mem_write,
  input  logic [4:0]         i_mem_dst,
  input  logic [NB_DATA-1:0] i_mem_data,
  output logic               o_stall,
  output logic               o_branch_taken,
  output logic [NB_DATA-1:0] o_branch_target,
  output logic               o_jump,
  output logic [NB_DATA-1:0] o_jump_target,
  output logic [NB_DATA-1:0] o_ra,
  output logic [NB_DATA-1:0] o_rb,
  output logic [NB_DATA-1:0] o_imm,
  output logic [NB_DATA-1:0] o_pc4,
  output logic [4:0]         o_rs,
  output logic [4:0]         o_rt,
  output logic [4:0]         o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_funct,
  output logic               o_wb_write,
  output logic               o_wb_mem_to_reg,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_ex_alu_src,
  output logic [1:0]         o_ex_reg_dst,
  output logic [1:0]         o_ex_alu_op
);

  localparam int AW = $clog2(N_REGS);

  logic [5:0]         w_op;
  logic [AW-1:0]      w_rs;
  logic [AW-1:0]      w_rt;
  logic [15:0]        w_imm16;
  logic [NB_DATA-1:0] w_sext;
  logic [NB_DATA-1:0] w_imm;
  logic [NB_DATA-1:0] w_rf_a;
  logic [NB_DATA-1:0] w_rf_b;
  logic [AW-1:0]      w_ex_dst;
  logic               w_ex_hit;
  logic               w_lu_stall;
  logic               w_br_stall;
  ctrl_t              w_ctrl;

  logic [NB_DATA-1:0] r_ra;
  logic [NB_DATA-1:0] r_rb;
  logic [NB_DATA-1:0] r_imm;
  logic [NB_DATA-1:0] r_pc4;
  logic [4:0]         r_rs;
  logic [4:0]         r_rt;
  logic [4:0]         r_rd;
  logic [4:0]         r_shamt;
  logic [5:0]         r_funct;
  ex_ctrl_t           r_ex;

  assign w_op    = i_instruction[31:26];
  assign w_rs    = i_instruction[21 +: AW];
  assign w_rt    = i_instruction[16 +: AW];
  assign w_imm16 = i_instruction[15:0];

  id_regfile #(
    .NB_DATA (NB_DATA),
    .N_REGS  (N_REGS)
  ) u_rf (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .i_we      (i_wb_write),
    .i_waddr   (i_wb_addr[AW-1:0]),
    .i_wdata   (i_wb_data),
    .o_rdata_a (w_rf_a),
    .o_rdata_b (w_rf_b)
  );

  // Main control decode from the opcode.
  always_comb begin
    w_ctrl = decode_op(w_op);
  end

  assign w_sext = {{(NB_DATA-16){w_imm16[15]}}, w_imm16};
  assign w_imm  = w_ctrl.zext ? {{(NB_DATA-16){1'b0}}, w_imm16}
                              : w_sext;

  assign w_ex_dst   = i_ex_dst[AW-1:0];
  assign w_ex_hit   = (w_ex_dst != '0) &&
                      ((w_ex_dst == w_rs) || (w_ex_dst == w_rt));
  assign w_lu_stall = i_ex_mem_read && w_ex_hit;

  assign o_stall = w_lu_stall | w_br_stall;

  assign o_branch_target =
    i_pc4 + {w_sext[NB_DATA-3:0], 2'b00};

`ifdef ID_BRANCH_EN
  logic [AW-1:0]      w_mem_dst;
  logic               w_mem_hit;
  logic               w_fwd_a;
  logic               w_fwd_b;
  logic [NB_DATA-1:0] w_cmp_a;
  logic [NB_DATA-1:0] w_cmp_b;
  logic               w_eq;

  assign w_mem_dst  = i_mem_dst[AW-1:0];
  assign w_mem_hit  = (w_mem_dst != '0) &&
                      ((w_mem_dst == w_rs) || (w_mem_dst == w_rt));
  assign w_br_stall = w_ctrl.branch &&
                      ((i_ex_write && w_ex_hit) ||
                       (i_mem_mem_read && w_mem_hit));

  assign w_fwd_a = i_mem_write && (w_mem_dst != '0) &&
                   (w_mem_dst == w_rs);
  assign w_fwd_b = i_mem_write && (w_mem_dst != '0) &&
                   (w_mem_dst == w_rt);
  assign w_cmp_a = w_fwd_a ? i_mem_data : w_rf_a;
  assign w_cmp_b = w_fwd_b ? i_mem_data : w_rf_b;
  assign w_eq    = (w_cmp_a == w_cmp_b);

  assign o_branch_taken = w_ctrl.branch &&
                          (w_eq ^ w_ctrl.bne) && !o_stall;
`else
  logic w_unused_br;

  assign w_br_stall     = 1'b0;
  assign o_branch_taken = 1'b0;
  assign w_unused_br    = ^{i_ex_write, i_mem_mem_read,
                            i_mem_write, i_mem_dst, i_mem_data,
                            w_ctrl.branch, w_ctrl.bne};
`endif

  assign o_jump        = w_ctrl.jump && !o_stall;
  assign o_jump_target = {i_pc4[NB_DATA-1:28],
                          i_instruction[25:0], 2'b00};

  // ID/EX register: reset > halt > bubble > load.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_ra    <= '0;
      r_rb    <= '0;
      r_imm   <= '0;
      r_pc4   <= '0;
      r_rs    <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
      r_shamt <= '0;
      r_funct <= '0;
      r_ex    <= '0;
    end else if (!i_halt) begin
      r_ra    <= w_rf_a;
      r_rb    <= w_rf_b;
      r_imm   <= w_imm;
      r_pc4   <= i_pc4;
      r_rs    <= i_instruction[25:21];
      r_rt    <= i_instruction[20:16];
      r_rd    <= i_instruction[15:11];
      r_shamt <= i_instruction[10:6];
      r_funct <= i_instruction[5:0];
      r_ex    <= (i_flush || o_stall) ? '0 : w_ctrl.ex;
    end
  end

  assign o_ra            = r_ra;
  assign o_rb            = r_rb;
  assign o_imm           = r_imm;
  assign o_pc4           = r_pc4;
  assign o_rs            = r_rs;
  assign o_rt            = r_rt;
  assign o_rd            = r_rd;
  assign o_shamt         = r_shamt;
  assign o_funct         = r_funct;
  assign o_wb_write      = r_ex.wb_write;
  assign o_wb_mem_to_reg = r_ex.mem_to_reg;
  assign o_mem_read      = r_ex.mem_read;
  assign o_mem_write     = r_ex.mem_write;
  assign o_ex_alu_src    = r_ex.alu_src;
  assign o_ex_reg_dst    = r_ex.reg_dst;
  assign o_ex_alu_op     = r_ex.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: vector table plus scoreboard for id_stage,
// with hand sequences for halt/flush and asynchronous reset.
module tb_id_stage;

`ifdef ID_BRANCH_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        halt, flush;
  logic [31:0] pc4, instr;
  logic        wbw;
  logic [4:0]  wba;
  logic [31:0] wbd;
  logic        exr, exw;
  logic [4:0]  exd;
  logic        mr, mw;
  logic [4:0]  md;
  logic [31:0] mdat;

  logic        stall, br, jmp;
  logic [31:0] btgt, jtgt;
  logic [31:0] ra, rb, imm, opc4;
  logic [4:0]  rs, rt, rd, sh;
  logic [5:0]  fn;
  logic        c_wb, c_m2r, c_mr, c_mw, c_src;
  logic [1:0]  c_dst, c_op;
  logic [8:0]  ctrl;

  assign ctrl = {c_wb, c_m2r, c_mr, c_mw, c_src, c_dst, c_op};

  id_stage dut (
    .i_clk           (clk),
    .i_reset         (rst_n),
    .i_halt          (halt),
    .i_flush         (flush),
    .i_pc4           (pc4),
    .i_instruction   (instr),
    .i_wb_write      (wbw),
    .i_wb_addr       (wba),
    .i_wb_data       (wbd),
    .i_ex_mem_read   (exr),
    .i_ex_write      (exw),
    .i_ex_dst        (exd),
    .i_mem_mem_read  (mr),
    .i_mem_write     (mw),
    .i_mem_dst       (md),
    .i_mem_data      (mdat),
    .o_stall         (stall),
    .o_branch_taken  (br),
    .o_branch_target (btgt),
    .o_jump          (jmp),
    .o_jump_target   (jtgt),
    .o_ra            (ra),
    .o_rb            (rb),
    .o_imm           (imm),
    .o_pc4           (opc4),
    .o_rs            (rs),
    .o_rt            (rt),
    .o_rd            (rd),
    .o_shamt         (sh),
    .o_funct         (fn),
    .o_wb_write      (c_wb),
    .o_wb_mem_to_reg (c_m2r),
    .o_mem_read      (c_mr),
    .o_mem_write     (c_mw),
    .o_ex_alu_src    (c_src),
    .o_ex_reg_dst    (c_dst),
    .o_ex_alu_op     (c_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc4;
    logic        wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        exr, exw;
    logic [4:0]  exd;
    logic        mr, mw;
    logic [4:0]  md;
    logic [31:0] mdat;
    logic        fl;
    logic        e_stall, e_br, e_jmp;
    logic [1:0]  tsel;
    logic [31:0] e_tgt;
    logic [8:0]  e_ctrl;
    logic [31:0] e_ra, e_rb, e_imm;
  } vec_t;

  typedef struct {
    logic [8:0]  ctrl;
    logic [31:0] ra, rb, imm, pc4;
  } exp_t;

  vec_t tv [22];
  exp_t q [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] rtype(input logic [4:0] s,
    input logic [4:0] t, input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op,
    input logic [4:0] s, input logic [4:0] t, input logic [15:0] i);
    return {op, s, t, i};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op,
    input logic [25:0] a);
    return {op, a};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins,
    input logic [31:0] p, input logic [8:0] c, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] im);
    vec_t v;
    v = '{default: '0};
    v.instr = ins; v.pc4 = p; v.e_ctrl = c;
    v.e_ra = a; v.e_rb = b; v.e_imm = im;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
    input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instr = v.instr; pc4 = v.pc4;
    wbw = v.wbw; wba = v.wba; wbd = v.wbd;
    exr = v.exr; exw = v.exw; exd = v.exd;
    mr = v.mr; mw = v.mw; md = v.md; mdat = v.mdat;
    flush = v.fl;
  endtask

  task automatic expect_reg(input vec_t v);
    exp_t e;
    e.ctrl = v.e_ctrl; e.ra = v.e_ra; e.rb = v.e_rb;
    e.imm = v.e_imm; e.pc4 = v.pc4;
    q.push_back(e);
  endtask

  task automatic check_reg(input string nm, input int idx);
    exp_t e;
    if (q.size() == 0) begin
      chk({nm, "_sb_empty"}, idx, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({nm, "_ctrl"}, idx, {23'd0, ctrl}, {23'd0, e.ctrl});
      chk({nm, "_ra"}, idx, ra, e.ra);
      chk({nm, "_rb"}, idx, rb, e.rb);
      chk({nm, "_imm"}, idx, imm, e.imm);
      chk({nm, "_pc4"}, idx, opc4, e.pc4);
    end
  endtask

  initial begin
    vec_t v;

    tv[0] = mk(itype(6'h3F, 0, 0, 0), 32'h4, 9'h000, 0, 0, 0);
    tv[0].wbw = 1; tv[0].wba = 1; tv[0].wbd = 32'd7;
    tv[1] = mk(itype(6'h08, 1, 2, 16'hFFFF), 32'h8, 9'h113,
               7, 0, 32'hFFFF_FFFF);
    tv[1].wbw = 1; tv[1].wba = 4; tv[1].wbd = 32'd7;
    tv[2] = mk(rtype(3, 4, 5, 6'h20), 32'hC, 9'h106,
               32'hDEAD_BEEF, 7, 32'h2820);
    tv[2].wbw = 1; tv[2].wba = 3; tv[2].wbd = 32'hDEAD_BEEF;
    tv[3] = mk(rtype(0, 3, 6, 6'h22), 32'h10, 9'h106,
               0, 32'hDEAD_BEEF, 32'h3022);
    tv[3].wbw = 1; tv[3].wba = 0; tv[3].wbd = 32'h1234;
    tv[4] = mk(itype(6'h0D, 1, 7, 16'h8001), 32'h14, 9'h113,
               7, 0, 32'h8001);
    tv[4].wbw = 1; tv[4].wba = 5; tv[4].wbd = 32'h55;
    tv[5] = mk(itype(6'h23, 1, 2, 16'h0004), 32'h18, 9'h1D0, 7, 0, 4);
    tv[6] = mk(rtype(2, 1, 8, 6'h20), 32'h1C, 9'h000, 0, 7, 32'h4020);
    tv[6].exr = 1; tv[6].exd = 2; tv[6].e_stall = 1;
    tv[7] = mk(rtype(2, 1, 8, 6'h20), 32'h1C, 9'h106, 0, 7, 32'h4020);
    tv[8] = mk(itype(6'h2B, 1, 4, 16'hFFFC), 32'h20, 9'h030,
               7, 7, 32'hFFFF_FFFC);
    tv[9] = mk(itype(6'h04, 1, 4, 16'hFFFF), 32'h100, 9'h001,
               7, 7, 32'hFFFF_FFFF);
    tv[9].e_br = BEN; tv[9].tsel = 1; tv[9].e_tgt = 32'hFC;
    tv[10] = tv[9];
    tv[10].mw = 1; tv[10].md = 4; tv[10].mdat = 9; tv[10].e_br = 0;
    tv[11] = mk(itype(6'h05, 1, 4, 16'hFFFF), 32'h100, 9'h001,
                7, 7, 32'hFFFF_FFFF);
    tv[11].mw = 1; tv[11].md = 4; tv[11].mdat = 9;
    tv[11].e_br = BEN; tv[11].tsel = 1; tv[11].e_tgt = 32'hFC;
    tv[12] = mk(itype(6'h04, 1, 4, 16'hFFFF), 32'h100,
                BEN ? 9'h000 : 9'h001, 7, 7, 32'hFFFF_FFFF);
    tv[12].exw = 1; tv[12].exd = 1; tv[12].e_stall = BEN;
    tv[13] = tv[12];
    tv[13].exw = 0; tv[13].exd = 0; tv[13].mr = 1; tv[13].md = 4;
    tv[14] = mk(jtype(6'h02, 26'h0123456), 32'hF000_0100, 9'h000,
                0, 0, 32'h3456);
    tv[14].e_jmp = 1; tv[14].tsel = 2; tv[14].e_tgt = 32'hF048_D158;
    tv[15] = mk(jtype(6'h03, 26'h0123456), 32'h200, 9'h108,
                0, 0, 32'h3456);
    tv[15].e_jmp = 1; tv[15].tsel = 2; tv[15].e_tgt = 32'h048_D158;
    tv[16] = tv[15];
    tv[16].exr = 1; tv[16].exd = 18; tv[16].e_stall = 1;
    tv[16].e_jmp = 0; tv[16].tsel = 0; tv[16].e_ctrl = 9'h000;
    tv[17] = mk(rtype(2, 1, 8, 6'h20), 32'h24, 9'h000, 0, 7, 32'h4020);
    tv[17].fl = 1; tv[17].exr = 1; tv[17].exd = 2; tv[17].e_stall = 1;
    tv[18] = mk(itype(6'h08, 1, 2, 16'hFFFF), 32'h28, 9'h000,
                7, 0, 32'hFFFF_FFFF);
    tv[18].fl = 1;
    tv[19] = mk(rtype(0, 1, 8, 6'h20), 32'h2C, 9'h106, 0, 7, 32'h4020);
    tv[19].exr = 1; tv[19].exd = 0;
    tv[20] = mk(itype(6'h04, 1, 3, 16'h0010), 32'h100, 9'h001,
                7, 32'hDEAD_BEEF, 32'h10);
    tv[20].tsel = 1; tv[20].e_tgt = 32'h140;
    tv[21] = mk(rtype(1, 2, 9, 6'h20), 32'h30, 9'h000, 7, 0, 32'h4820);
    tv[21].exr = 1; tv[21].exd = 2; tv[21].e_stall = 1;

    rst_n = 1'b0; halt = 1'b0;
    drive(mk(32'd0, 32'd0, 9'd0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 0, {23'd0, ctrl}, 32'd0);
    chk("rst_ra", 0, ra, 32'd0);
    chk("rst_pc4", 0, opc4, 32'd0);
    chk("rst_fields", 0, {9'd0, rs, rt, rd, sh, fn}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      drive(tv[i]);
      @(negedge clk);
      chk("stall", i, {31'd0, stall}, {31'd0, tv[i].e_stall});
      chk("br", i, {31'd0, br}, {31'd0, tv[i].e_br});
      chk("jmp", i, {31'd0, jmp}, {31'd0, tv[i].e_jmp});
      if (tv[i].tsel == 2'd1) chk("btgt", i, btgt, tv[i].e_tgt);
      if (tv[i].tsel == 2'd2) chk("jtgt", i, jtgt, tv[i].e_tgt);
      expect_reg(tv[i]);
      @(posedge clk);
      #1;
      check_reg("vec", i);
    end

    v = mk(itype(6'h08, 1, 2, 16'hFFFF), 32'h40, 9'h113,
           7, 0, 32'hFFFF_FFFF);
    drive(v);
    expect_reg(v);
    @(posedge clk);
    #1;
    check_reg("pre_halt", 0);
    for (int k = 0; k < 3; k++) begin
      drive(mk(rtype(3, 4, 5, 6'h20), 32'h44, 9'h0, 0, 0, 0));
      halt = 1'b1;
      expect_reg(v);
      @(posedge clk);
      #1;
      check_reg("halt", k);
    end
    halt = 1'b0;
    v = mk(rtype(3, 4, 5, 6'h20), 32'h44, 9'h000,
           32'hDEAD_BEEF, 7, 32'h2820);
    v.fl = 1;
    drive(v);
    expect_reg(v);
    @(posedge clk);
    #1;
    check_reg("flush", 0);

    v = mk(rtype(3, 4, 5, 6'h20), 32'h48, 9'h106,
           32'hDEAD_BEEF, 7, 32'h2820);
    drive(v);
    expect_reg(v);
    @(posedge clk);
    #1;
    check_reg("pre_rst", 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 0, {23'd0, ctrl}, 32'd0);
    chk("arst_ra", 0, ra, 32'd0);
    chk("arst_pc4", 0, opc4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = mk(rtype(5, 1, 10, 6'h20), 32'h4C, 9'h106, 0, 0, 32'h5020);
    drive(v);
    expect_reg(v);
    @(posedge clk);
    #1;
    check_reg("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised MIPS instruction-decode stage with its ID/EX pipeline register. It contains the register file, the main control decoder, immediate extension, load-use and branch hazard detection, and optional in-ID branch resolution. It sits between the IF/ID register and the execute stage, drives the PC/IF-ID freeze (`o_stall`), and supplies the branch and jump redirects.

## Interface
Parameters:
- `NB_DATA`, 32: datapath width; `pc4`, register and immediate width.
- `N_REGS`, 32: register count, power of two, at most 32. Address width is clog2(`N_REGS`); upper instruction-field bits are ignored.

Ports:
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_reset` in 1: reset, asynchronous, active-low.
- `i_halt` in 1: debug freeze; ID/EX register holds its value.
- `i_flush` in 1: load a bubble into ID/EX.
- `i_pc4` in `NB_DATA`: PC+4 of the instruction in ID.
- `i_instruction` in 32: instruction in ID.
- `i_wb_write` in 1, `i_wb_addr` in 5, `i_wb_data` in `NB_DATA`: writeback port.
- `i_ex_mem_read` in 1, `i_ex_write` in 1, `i_ex_dst` in 5: the instruction currently in EX.
- `i_mem_mem_read` in 1, `i_mem_write` in 1, `i_mem_dst` in 5, `i_mem_data` in `NB_DATA`: the instruction currently in MEM.
- `o_stall` out 1: combinational; freeze PC and IF/ID.
- `o_branch_taken` out 1, `o_branch_target` out `NB_DATA`: combinational branch redirect.
- `o_jump` out 1, `o_jump_target` out `NB_DATA`: combinational J/JAL redirect.
- `o_ra`, `o_rb`, `o_imm`, `o_pc4` out `NB_DATA`: registered operands.
- `o_rs`, `o_rt`, `o_rd`, `o_shamt` out 5 each; `o_funct` out 6: registered instruction fields.
- `o_wb_write`, `o_wb_mem_to_reg`, `o_mem_read`, `o_mem_write`, `o_ex_alu_src` out 1 each: registered controls.
- `o_ex_reg_dst` out 2: 00 = rt, 01 = rd, 10 = link (r31, data `o_pc4`).
- `o_ex_alu_op` out 2: 00 = add, 01 = sub/compare, 10 = funct-decoded, 11 = immediate-op.

## Operation
- **Register file**
  - Two combinational read ports, one synchronous write port.
  - r0 always reads 0; writes to r0 are ignored.
  - Write-first bypass: when `i_wb_write` is high and `i_wb_addr` equals a read address, that port returns `i_wb_data` in the same cycle.
- **Decode**, per opcode (all unlisted controls are 0):
  - R-type (0x00): write, reg_dst 01, alu_op 10.
  - LW (0x23): write, mem_to_reg, mem_read, alu_src, alu_op 00.
  - SW (0x2B): mem_write, alu_src, alu_op 00.
  - BEQ (0x04), BNE (0x05): alu_op 01.
  - ADDI, SLTI, ANDI, ORI, XORI, LUI (0x08, 0x0A, 0x0C, 0x0D, 0x0E, 0x0F): write, alu_src, alu_op 11.
  - J (0x02): jump.
  - JAL (0x03): jump, write, reg_dst 10.
  - Any other opcode decodes to all controls 0 (NOP).
- **Immediate**: zero-extended for ANDI/ORI/XORI; sign-extended for everything else.
- **Load-use stall**: raised when `i_ex_mem_read` is high, `i_ex_dst` is nonzero, and `i_ex_dst` equals rs or rt.
- **Branch stall**, for BEQ/BNE with `ID_BRANCH_EN` defined; raised when either holds:
  - `i_ex_write` is high and `i_ex_dst` (nonzero) matches rs or rt.
  - `i_mem_mem_read` is high and `i_mem_dst` (nonzero) matches rs or rt.
- **Branch compare**:
  - Operands come from `i_mem_data` when `i_mem_write` is high, `i_mem_dst` is nonzero and matches; otherwise from the register file.
  - BEQ is taken on equal operands; BNE on unequal operands.
  - `o_branch_target` = `i_pc4` + (sext(imm) << 2), modulo 2^`NB_DATA`.
- **Jump**: `o_jump_target` = {`i_pc4`[`NB_DATA`-1:28], addr26, 2'b00}.
- `o_branch_taken` and `o_jump` are forced to 0 while `o_stall` is high.
- **ID/EX update priority**: reset > `i_halt` (hold) > `i_flush` (bubble) > `o_stall` (bubble) > normal load.
  - A bubble sets all control outputs to 0.
  - During a bubble, data and field outputs load normally.

## Timing
- On reset, every registered output is 0 (a NOP) and every register-file entry is 0.
- Reset assertion clears state asynchronously, even mid-stall or mid-halt.
- Decode-to-ID/EX latency is 1 cycle.
- `o_stall`, `o_branch_*` and `o_jump*` are combinational in the current cycle. They are not gated by `i_halt`.
- A stall lasts exactly as long as its hazard condition: 1 cycle for load-use, at most 2 cycles for a branch.
- Simultaneous `i_flush` and `o_stall` produce a single bubble.
- A writeback to a register being read in the same cycle yields the new value.

## Configuration
- `ID_BRANCH_EN` defined:
  - In-ID branch compare, EX/MEM forwarding into the comparator, and branch stalls are all compiled in.
- `ID_BRANCH_EN` undefined:
  - `o_branch_taken` is tied to 0 and branch stalls are absent.
  - BEQ/BNE still decode to alu_op 01, so EX resolves them.

## Structure
- Package `id_pkg`: opcode and funct constants, the `o_ex_reg_dst` and `o_ex_alu_op` encodings, and a control-bundle struct/typedef.
- Sub-module `id_regfile` (parametrised `NB_DATA`, `N_REGS`): register storage, r0 handling and write-first bypass.

## Test plan
- **Reset**: `i_reset` low mid-run → all outputs 0 immediately; a read of r5 afterwards returns 0.
- **Bypass**: write r3 = 0xDEADBEEF while an ADD reads r3 in the same cycle → `o_ra` = 0xDEADBEEF next cycle; a write to r0 is ignored and `o_ra` stays 0.
- **Load-use**: LW r2 in EX (`i_ex_dst` = 2), ADD using r2 in ID → `o_stall` high for 1 cycle, bubble with all controls 0, then the ADD loads.
- **Taken branch** (`ID_BRANCH_EN`): BEQ r1, r4 with both registers = 7, `i_pc4` = 0x100, imm = 0xFFFF → taken, target 0xFC.
- **MEM-forwarded branch**: same BEQ with `i_mem_dst` = 4, `i_mem_data` = 9 → not taken.
- **Halt then flush**: `i_halt` high 3 cycles → ID/EX unchanged; then `i_flush` high → next cycle all controls 0.
